// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings, scan codes and helpers for the snake direction scheduler
package snake_pkg;

  // Committed direction encodings as seen by the game engine
  localparam logic [2:0] DIR_W = 3'b011;
  localparam logic [2:0] DIR_A = 3'b010;
  localparam logic [2:0] DIR_S = 3'b001;
  localparam logic [2:0] DIR_D = 3'b000;

  // PS/2 set-2 scan codes of interest
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Scan-code prefix tracking: idle, after a break prefix, after an extended prefix
  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_BRK  = 2'd1,
    DEC_EXT  = 2'd2
  } dec_state_t;

  // Reverse of a direction; W<->S and A<->D. Unused codes map to themselves.
  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      DIR_W:   opposite = DIR_S;
      DIR_S:   opposite = DIR_W;
      DIR_A:   opposite = DIR_D;
      DIR_D:   opposite = DIR_A;
      default: opposite = d;
    endcase
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// rtl/dir_fifo.sv - small synchronous FIFO of 3-bit direction entries
module dir_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [2:0]    din,
  output logic [2:0]    head,
  output logic [2:0]    tail,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign tail    = mem[wr_ptr - PW'(1)];

  // Entry storage; contents beyond the valid window are don't-care
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; flush empties the queue and wins over push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snake_dir_scheduler.sv
// rtl/snake_dir_scheduler.sv - scan-code decoder, reversal filter and per-tick direction commit
module snake_dir_scheduler
  import snake_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          code_valid,
  input  logic [7:0]    code,
  input  logic          tick,
  output logic [2:0]    direction,
  output logic          dir_update,
  output logic          reset_req,
  output logic [CW-1:0] q_count,
  output logic          overflow
);

  dec_state_t state;
  dec_state_t state_nxt;
  logic       cand_valid;
  logic [2:0] cand;
  logic       space_evt;

  logic [2:0] fifo_head;
  logic [2:0] fifo_tail;
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] ref_dir;
  logic       push_req;
  logic       pop_req;
  logic       overflow_nxt;

  // Decoder state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DEC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Decoder next state; emits a direction candidate or a space event on make codes
  always_comb begin
    state_nxt  = state;
    cand_valid = 1'b0;
    cand       = DIR_S;
    space_evt  = 1'b0;
    if (code_valid) begin
      case (state)
        DEC_IDLE: begin
          case (code)
            SC_BREAK: state_nxt = DEC_BRK;
            SC_EXT:   state_nxt = DEC_EXT;
            SC_W:     begin cand_valid = 1'b1; cand = DIR_W; end
            SC_A:     begin cand_valid = 1'b1; cand = DIR_A; end
            SC_S:     begin cand_valid = 1'b1; cand = DIR_S; end
            SC_D:     begin cand_valid = 1'b1; cand = DIR_D; end
            SC_SPACE: space_evt = 1'b1;
            default:  state_nxt = DEC_IDLE;
          endcase
        end
        DEC_BRK: begin
          // The released key's code is swallowed; releases never steer the snake
          state_nxt = DEC_IDLE;
        end
        DEC_EXT: begin
          state_nxt = DEC_IDLE;
          case (code)
            SC_BREAK: state_nxt = DEC_BRK;
            SC_UP:    begin cand_valid = 1'b1; cand = DIR_W; end
            SC_LEFT:  begin cand_valid = 1'b1; cand = DIR_A; end
            SC_DOWN:  begin cand_valid = 1'b1; cand = DIR_S; end
            SC_RIGHT: begin cand_valid = 1'b1; cand = DIR_D; end
            default:  state_nxt = DEC_IDLE;
          endcase
        end
        default: state_nxt = DEC_IDLE;
      endcase
    end
  end

  // Compare against the last queued command so a burst of keys is filtered as a chain;
  // with one entry being popped this cycle, that entry becomes the committed direction anyway
  assign ref_dir      = fifo_empty ? direction : fifo_tail;
  assign push_req     = cand_valid && (cand != ref_dir) && (cand != opposite(ref_dir));
  assign pop_req      = tick && !fifo_empty && !space_evt;
  assign overflow_nxt = push_req && fifo_full && !pop_req;

  dir_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .flush (space_evt),
    .din   (cand),
    .head  (fifo_head),
    .tail  (fifo_tail),
    .count (q_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Committed direction and one-cycle status pulses; space restarts the game and beats a tick
  always_ff @(posedge clk) begin
    if (rst) begin
      direction  <= DIR_S;
      dir_update <= 1'b0;
      reset_req  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dir_update <= 1'b0;
      reset_req  <= 1'b0;
      overflow   <= overflow_nxt;
      if (space_evt) begin
        direction  <= DIR_S;
        dir_update <= 1'b1;
        reset_req  <= 1'b1;
      end else if (pop_req) begin
        direction  <= fifo_head;
        dir_update <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_dir_scheduler.sv
// tb/tb_snake_dir_scheduler.sv - vector table plus randomized run against a queue-based model
module tb_snake_dir_scheduler;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] W = 3'b011;
  localparam logic [2:0] A = 3'b010;
  localparam logic [2:0] S = 3'b001;
  localparam logic [2:0] D = 3'b000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          code_valid = 1'b0;
  logic [7:0]    code = 8'h00;
  logic          tick = 1'b0;
  logic [2:0]    direction;
  logic          dir_update;
  logic          reset_req;
  logic [CW-1:0] q_count;
  logic          overflow;

  snake_dir_scheduler #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code       (code),
    .tick       (tick),
    .direction  (direction),
    .dir_update (dir_update),
    .reset_req  (reset_req),
    .q_count    (q_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r;
    bit         cv;
    logic [7:0] c;
    bit         t;
    logic [2:0] dir;
    bit         upd;
    bit         rr;
    bit         ov;
    int         cnt;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model: committed direction, pending commands, prefix flags, expected pulses
  int mq[$];
  int mdir;
  bit pend_break;
  bit pend_ext;
  bit e_upd;
  bit e_rr;
  bit e_ov;

  task automatic add(input bit r, input bit cv, input logic [7:0] c, input bit t,
                     input logic [2:0] d, input bit u, input bit rr, input bit ov, input int n);
    vec_t v;
    v.r = r; v.cv = cv; v.c = c; v.t = t;
    v.dir = d; v.upd = u; v.rr = rr; v.ov = ov; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at step %0d: got %0d, expected %0d", nm, idx, act, exp);
  endtask

  task automatic model_step(input bit r, input bit cv, input logic [7:0] c, input bit t);
    bit space;
    bit have;
    bit pop_ok;
    bit do_push;
    int cd;
    int rf;
    space = 0; have = 0; cd = 0; do_push = 0;
    e_upd = 0; e_rr = 0; e_ov = 0;
    if (r) begin
      mq.delete();
      mdir = S;
      pend_break = 0;
      pend_ext = 0;
      return;
    end
    if (cv) begin
      if (pend_break) begin
        pend_break = 0;
      end else if (pend_ext) begin
        pend_ext = 0;
        if (c == 8'hF0) pend_break = 1;
        else if (c == 8'h75) begin have = 1; cd = W; end
        else if (c == 8'h6B) begin have = 1; cd = A; end
        else if (c == 8'h72) begin have = 1; cd = S; end
        else if (c == 8'h74) begin have = 1; cd = D; end
      end else begin
        if (c == 8'hF0) pend_break = 1;
        else if (c == 8'hE0) pend_ext = 1;
        else if (c == 8'h1D) begin have = 1; cd = W; end
        else if (c == 8'h1C) begin have = 1; cd = A; end
        else if (c == 8'h1B) begin have = 1; cd = S; end
        else if (c == 8'h23) begin have = 1; cd = D; end
        else if (c == 8'h29) space = 1;
      end
    end
    if (space) begin
      mq.delete();
      mdir = S;
      e_upd = 1;
      e_rr = 1;
      return;
    end
    pop_ok = t && (mq.size() > 0);
    rf = (mq.size() > 0) ? mq[$] : mdir;
    // Reversal pairs differ only in bit 1 of the encoding
    if (have && cd != rf && cd != (rf ^ 2)) begin
      if (mq.size() == DEPTH && !pop_ok) e_ov = 1;
      else do_push = 1;
    end
    if (pop_ok) begin
      mdir = mq.pop_front();
      e_upd = 1;
    end
    if (do_push) mq.push_back(cd);
  endtask

  task automatic drive(input bit r, input bit cv, input logic [7:0] c, input bit t);
    rst = r; code_valid = cv; code = c; tick = t;
    model_step(r, cv, c, t);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pool [16] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74,
                            8'hF0, 8'hE0, 8'h29, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h12};

  initial begin
    // reset, then A queued and committed
    add(1, 0, 8'h00, 0, S, 0, 0, 0, 0);
    add(0, 1, 8'h1C, 0, S, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, S, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, A, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, A, 0, 0, 0, 0);
    // reversal of S dropped, A accepted
    add(1, 0, 8'h00, 0, S, 0, 0, 0, 0);
    add(0, 1, 8'h1D, 0, S, 0, 0, 0, 0);
    add(0, 1, 8'h1C, 0, S, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, A, 1, 0, 0, 0);
    // A then W back to back, two ticks, then a release
    add(1, 0, 8'h00, 0, S, 0, 0, 0, 0);
    add(0, 1, 8'h1C, 0, S, 0, 0, 0, 1);
    add(0, 1, 8'h1D, 0, S, 0, 0, 0, 2);
    add(0, 0, 8'h00, 1, A, 1, 0, 0, 1);
    add(0, 0, 8'h00, 0, A, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, A, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, W, 1, 0, 0, 0);
    add(0, 1, 8'hF0, 0, W, 0, 0, 0, 0);
    add(0, 1, 8'h1C, 0, W, 0, 0, 0, 0);
    add(0, 1, 8'h1C, 0, W, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, A, 1, 0, 0, 0);
    // extended up make, then extended up release
    add(0, 1, 8'hE0, 0, A, 0, 0, 0, 0);
    add(0, 1, 8'h75, 0, A, 0, 0, 0, 1);
    add(0, 1, 8'hE0, 0, A, 0, 0, 0, 1);
    add(0, 1, 8'hF0, 0, A, 0, 0, 0, 1);
    add(0, 1, 8'h75, 0, A, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, W, 1, 0, 0, 0);
    // fill A,W,D,S; fifth push overflows; push with tick on full is accepted
    add(0, 1, 8'h1C, 0, W, 0, 0, 0, 1);
    add(0, 1, 8'h1D, 0, W, 0, 0, 0, 2);
    add(0, 1, 8'h23, 0, W, 0, 0, 0, 3);
    add(0, 1, 8'h1B, 0, W, 0, 0, 0, 4);
    add(0, 1, 8'h1C, 0, W, 0, 0, 1, 4);
    add(0, 0, 8'h00, 0, W, 0, 0, 0, 4);
    add(0, 1, 8'h1C, 1, A, 1, 0, 0, 4);
    // three entries left, space with tick flushes and resets direction
    add(0, 0, 8'h00, 1, W, 1, 0, 0, 3);
    add(0, 1, 8'h29, 1, S, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, S, 0, 0, 0, 0);
    // reset after extended prefix drops the prefix
    add(0, 1, 8'hE0, 0, S, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, S, 0, 0, 0, 0);
    add(0, 1, 8'h75, 0, S, 0, 0, 0, 0);
    add(0, 1, 8'h1C, 0, S, 0, 0, 0, 1);
    // unknown extended code returns to idle; typematic repeat absorbed
    add(0, 1, 8'hE0, 0, S, 0, 0, 0, 1);
    add(0, 1, 8'h1D, 0, S, 0, 0, 0, 1);
    add(0, 1, 8'h1D, 0, S, 0, 0, 0, 2);
    add(0, 1, 8'h1D, 0, S, 0, 0, 0, 2);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].cv, vecs[i].c, vecs[i].t);
      chk("vec_direction",  i, int'(direction),  int'(vecs[i].dir));
      chk("vec_dir_update", i, int'(dir_update), int'(vecs[i].upd));
      chk("vec_reset_req",  i, int'(reset_req),  int'(vecs[i].rr));
      chk("vec_overflow",   i, int'(overflow),   int'(vecs[i].ov));
      chk("vec_q_count",    i, int'(q_count),    vecs[i].cnt);
    end

    for (int i = 0; i < 3000; i++) begin
      bit         r;
      bit         cv;
      bit         t;
      logic [7:0] c;
      r  = (i == 0) || ($urandom_range(0, 299) == 0);
      cv = ($urandom_range(0, 1) == 1);
      t  = ($urandom_range(0, 5) == 0);
      c  = pool[$urandom_range(0, 15)];
      drive(r, cv, c, t);
      chk("rnd_direction",  i, int'(direction),  mdir);
      chk("rnd_dir_update", i, int'(dir_update), int'(e_upd));
      chk("rnd_reset_req",  i, int'(reset_req),  int'(e_rr));
      chk("rnd_overflow",   i, int'(overflow),   int'(e_ov));
      chk("rnd_q_count",    i, int'(q_count),    mq.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
